obc_da_engine: RTL and testbench

OBC_DA_ENGINE -- requirements
Module: obc_da_engine

---
 rtl/obc_da_engine.sv | 130 +++++++++++++
 tb/tb_obc_da_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/obc_da_engine.sv
// rtl/obc_da_engine.sv - bit-serial offset-binary-coded distributed-arithmetic dot-product engine
module obc_da_engine #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 16,
  parameter int TBL_W = 32,
  parameter int ACC_W = TBL_W + IN_W + $clog2(N_CH / 2) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_CH*IN_W-1:0]        in_data,
  input  logic                        cfg_we,
  input  logic [$clog2(N_CH+1)-1:0]   cfg_addr,
  input  logic [TBL_W-1:0]            cfg_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic                        busy,
  output logic                        cfg_err
);

  localparam int P  = N_CH / 2;
  localparam int NE = N_CH + 1;
  localparam int AW = $clog2(NE);
  localparam int CW = $clog2(IN_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [N_CH*IN_W-1:0]   samp;
  logic [CW-1:0]          cnt;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       term;
  logic [ACC_W-1:0]       off_ext;
  logic                   addr_ok;
  logic                   tbl_we;

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;
  assign addr_ok  = (cfg_addr <= AW'(2 * P));
  assign tbl_we   = cfg_we && in_ready && addr_ok;

  // Entries 0..2P-1 are the per-pair E0/E1 values, entry 2P is the offset.
  genvar gi;
  generate
    for (gi = 0; gi < NE; gi++) begin : g_tbl
      logic [TBL_W-1:0] ent;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ent <= '0;
        else if (tbl_we && cfg_addr == AW'(gi))
          ent <= cfg_data;
      end
    end
  endgenerate

  assign off_ext = {{(ACC_W-TBL_W){g_tbl[2*P].ent[TBL_W-1]}}, g_tbl[2*P].ent};

  // samp shifts left every RUN cycle, so each channel's MSB is the current bit.
  genvar gp;
  generate
    for (gp = 0; gp < P; gp++) begin : g_pair
      logic             bit_a;
      logic             bit_b;
      logic [ACC_W-1:0] e0;
      logic [ACC_W-1:0] e1;
      logic [ACC_W-1:0] pick;
      logic [ACC_W-1:0] run;
      assign bit_a = samp[(2*gp+1)*IN_W-1];
      assign bit_b = samp[(2*gp+2)*IN_W-1];
      assign e0    = {{(ACC_W-TBL_W){g_tbl[2*gp].ent[TBL_W-1]}}, g_tbl[2*gp].ent};
      assign e1    = {{(ACC_W-TBL_W){g_tbl[2*gp+1].ent[TBL_W-1]}}, g_tbl[2*gp+1].ent};
      assign pick  = (bit_a ^ bit_b) ? e1 : e0;
      if (gp == 0) begin : g_first
        assign run = bit_a ? pick : -pick;
      end else begin : g_next
        assign run = g_pair[gp-1].run + (bit_a ? pick : -pick);
      end
    end
  endgenerate

  assign term = g_pair[P-1].run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      samp      <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !(in_ready && addr_ok);
      case (state)
        IDLE: begin
          if (in_valid) begin
            samp  <= in_data;
            acc   <= '0;
            cnt   <= CW'(IN_W - 1);
            state <= RUN;
          end
        end
        RUN: begin
          samp <= samp << 1;
          cnt  <= cnt - 1'b1;
          // The sign bit carries negative weight, hence the subtraction first.
          if (cnt == CW'(IN_W - 1)) begin
            acc <= (acc << 1) - term;
          end else if (cnt == '0) begin
            out_data  <= (acc << 1) + term + off_ext;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc <= (acc << 1) + term;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obc_da_engine.sv
// tb/tb_obc_da_engine.sv - directed self-checking bench for obc_da_engine
module tb_obc_da_engine;

  localparam int N_CH  = 4;
  localparam int IN_W  = 4;
  localparam int TBL_W = 32;
  localparam int ACC_W = 38;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = '0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_addr = '0;
  logic [31:0]       cfg_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_data;
  logic              busy;
  logic              cfg_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  obc_da_engine #(.N_CH(N_CH), .IN_W(IN_W), .TBL_W(TBL_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .cfg_err(cfg_err)
  );

  longint           m_tbl [5] = '{default: 0};
  bit               m_idle = 1'b1;
  bit               m_valid = 1'b0;
  bit               m_err = 1'b0;
  int               m_left = 0;
  logic [ACC_W-1:0] m_out = '0;
  logic [ACC_W-1:0] m_pend = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lit(input longint v);
    logic [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return {{(64-ACC_W){1'b0}}, t};
  endfunction

  function automatic logic [15:0] pack(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Closed form: y = sum_p (xa+xb+1)*E0 + (xa-xb)*E1 + OFF, wrapped to ACC_W.
  function automatic logic [ACC_W-1:0] calc(input logic [15:0] d);
    longint   x [4];
    longint   y;
    logic [3:0] nib;
    y = m_tbl[4];
    for (int k = 0; k < 4; k++) begin
      nib = d[k*4 +: 4];
      x[k] = longint'($signed(nib));
    end
    for (int p = 0; p < 2; p++)
      y += (x[2*p] + x[2*p+1] + 1) * m_tbl[2*p] + (x[2*p] - x[2*p+1]) * m_tbl[2*p+1];
    return y[ACC_W-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit idle0;
    if (!rst_n) begin
      m_tbl   = '{default: 0};
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_left  = 0;
      m_out   = '0;
    end else begin
      idle0 = m_idle;
      m_err = cfg_we && !(idle0 && cfg_addr <= 3'd4);
      if (cfg_we && idle0 && cfg_addr <= 3'd4)
        m_tbl[cfg_addr] = longint'($signed(cfg_data));
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0;
          m_idle  = 1'b1;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_out   = m_pend;
        end
      end else if (idle0 && in_valid) begin
        m_pend = calc(in_data);
        m_left = IN_W;
        m_idle = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_idle);
    chk("busy", busy, !m_idle);
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_out);
    chk("cfg_err", cfg_err, m_err);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_cfg(input int a, input int v);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 32'(v);
    tick;
    cfg_we = 1'b0;
  endtask

  // mode 0: plain, 1: rejected write during RUN, 2: offset write on the accepting edge
  task automatic xform(input logic [15:0] d, input longint want, input int mode, input int hold);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    if (mode == 2) begin
      cfg_we   = 1'b1;
      cfg_addr = 3'd4;
      cfg_data = 32'(-9);
    end
    tick;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    n = 0;
    if (mode == 1) begin
      cfg_we   = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = 32'd99;
      tick;
      cfg_we = 1'b0;
      n = 1;
      chk("cfg_err_run", cfg_err, 1);
    end
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk("latency", n, IN_W);
    chk("result", out_data, lit(want));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("idle_after", in_ready, 1);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    tick;

    do_cfg(0, 3);
    do_cfg(1, -1);
    do_cfg(2, 7);
    do_cfg(3, -1);
    do_cfg(4, -10);
    chk("model_pin_a", calc(pack(1, 1, 1, 1)), lit(20));
    chk("model_pin_b", calc(pack(-8, -8, -8, -8)), lit(-160));

    xform(pack(1, 1, 1, 1), 20, 0, 0);
    xform(pack(7, -1, 3, -2), 12, 0, 0);
    xform(pack(-8, 0, 0, 0), -16, 0, 0);
    xform(pack(-8, -8, -8, -8), -160, 0, 10);
    xform(pack(1, 1, 1, 1), 20, 1, 0);

    do_cfg(5, 123);
    chk("cfg_err_addr", cfg_err, 1);
    tick;
    chk("cfg_err_clear", cfg_err, 0);
    xform(pack(1, 1, 1, 1), 20, 0, 0);

    xform(pack(1, 1, 1, 1), 21, 2, 0);
    do_cfg(4, -10);

    in_data  = pack(1, 1, 1, 1);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_busy", busy, 0);
    tick;
    rst_n = 1'b1;
    repeat (6) tick;
    xform(pack(1, 1, 1, 1), 0, 0, 0);
    xform(pack(7, -1, 3, -2), 0, 0, 0);

    do_cfg(0, 3);
    do_cfg(1, -1);
    do_cfg(2, 7);
    do_cfg(3, -1);
    do_cfg(4, -10);
    xform(pack(7, -1, 3, -2), 12, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
